// File: rtl/pseudo_spi_pkg.sv
// Shared encodings and bit-timing constants for the pseudo-SPI TX and RX interfaces.
package pseudo_spi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_SHFT  = 3'd2,
        ST_WRITE = 3'd3,
        ST_NEXT  = 3'd4,
        ST_DONE  = 3'd5
    } spi_state_e;

    localparam int BIT_CYCLES   = 5;
    localparam int SEL_CYCLES   = 2;
    localparam int PHASE_W      = 3;
    localparam int SEL_W        = 2;

    // Phase counter runs BIT_CYCLES-1 down to 0 within each bit window.
    localparam logic [PHASE_W-1:0] PHASE_FIRST  = PHASE_W'(BIT_CYCLES - 1);
    localparam logic [PHASE_W-1:0] SCLK1_PHASE  = PHASE_W'(3);
    localparam logic [PHASE_W-1:0] SCLK2_PHASE  = PHASE_W'(1);
    localparam logic [PHASE_W-1:0] SAMPLE_PHASE = PHASE_W'(0);
    localparam logic [SEL_W-1:0]   SEL_LAST     = SEL_W'(SEL_CYCLES - 1);

endpackage

// File: rtl/pseudo_spi_bit_timer.sv
// Per-bit phase counter with SCLK1/SCLK2/sample strobe decode; idles at the first phase
// whenever run is low so every window starts aligned.
module pseudo_spi_bit_timer
    import pseudo_spi_pkg::*;
(
    input  logic CLK,
    input  logic RST,
    input  logic run,
    output logic sclk1,
    output logic sclk2,
    output logic sample
);

    logic [PHASE_W-1:0] phase;

    always_ff @(posedge CLK) begin
        if (RST) begin
            phase <= PHASE_FIRST;
        end else if (!run || phase == SAMPLE_PHASE) begin
            phase <= PHASE_FIRST;
        end else begin
            phase <= phase - PHASE_W'(1);
        end
    end

    assign sclk1  = run && (phase == SCLK1_PHASE);
    assign sclk2  = run && (phase == SCLK2_PHASE);
    assign sample = run && (phase == SAMPLE_PHASE);

endmodule

// File: rtl/pseudo_spi_rx_intf.sv
// Pseudo-SPI readback: loads the device scan chain, shifts words in LSB-first and
// writes them to consecutive SRAM addresses. Outputs decode registered state only.
module pseudo_spi_rx_intf
    import pseudo_spi_pkg::*;
#(
    parameter int MEMORY_DATA_WIDTH = 8,
    parameter int MEMORY_ADDR_WIDTH = 10,
    parameter int RESERVED_DATA_LEN = 8
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic                         BGN,
    input  logic [MEMORY_ADDR_WIDTH-1:0] ADDR_BGN,
    input  logic [RESERVED_DATA_LEN-1:0] DATA_LEN,
    input  logic                         SPI_SI,
    output logic                         SCLK1,
    output logic                         SCLK2,
    output logic                         SEL,
    output logic [MEMORY_ADDR_WIDTH-1:0] A,
    output logic [MEMORY_DATA_WIDTH-1:0] PO,
    output logic                         CEN,
    output logic                         D_WE,
    output logic                         spi_MUX,
    output logic                         spi_is_done
);

    localparam int BIT_W = (MEMORY_DATA_WIDTH > 1) ? $clog2(MEMORY_DATA_WIDTH) : 1;
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(MEMORY_DATA_WIDTH - 1);

    spi_state_e                   state;
    logic [MEMORY_ADDR_WIDTH-1:0] addr;
    logic [RESERVED_DATA_LEN-1:0] words;
    logic [BIT_W-1:0]             bit_cnt;
    logic [SEL_W-1:0]             load_cnt;
    logic [MEMORY_DATA_WIDTH-1:0] shreg;
    logic                         sample;

    pseudo_spi_bit_timer u_bit_timer (
        .CLK    (CLK),
        .RST    (RST),
        .run    (state == ST_SHFT),
        .sclk1  (SCLK1),
        .sclk2  (SCLK2),
        .sample (sample)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= ST_IDLE;
            addr     <= '0;
            words    <= '0;
            bit_cnt  <= '0;
            load_cnt <= '0;
            shreg    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (BGN) begin
                        addr     <= ADDR_BGN;
                        words    <= DATA_LEN;
                        load_cnt <= SEL_LAST;
                        state    <= (DATA_LEN == '0) ? ST_DONE : ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (!BGN) begin
                        state <= ST_IDLE;
                    end else if (load_cnt == '0) begin
                        bit_cnt <= BIT_LAST;
                        state   <= ST_SHFT;
                    end else begin
                        load_cnt <= load_cnt - SEL_W'(1);
                    end
                end
                ST_SHFT: begin
                    if (!BGN) begin
                        state <= ST_IDLE;
                    end else if (sample) begin
                        // Shift right so the first received bit ends up in bit 0.
                        shreg <= {SPI_SI, shreg[MEMORY_DATA_WIDTH-1:1]};
                        if (bit_cnt == '0) begin
                            state <= ST_WRITE;
                        end else begin
                            bit_cnt <= bit_cnt - BIT_W'(1);
                        end
                    end
                end
                ST_WRITE: begin
                    state <= BGN ? ST_NEXT : ST_IDLE;
                end
                ST_NEXT: begin
                    if (!BGN) begin
                        state <= ST_IDLE;
                    end else begin
                        addr    <= addr + MEMORY_ADDR_WIDTH'(1);
                        words   <= words - RESERVED_DATA_LEN'(1);
                        bit_cnt <= BIT_LAST;
                        state   <= (words == RESERVED_DATA_LEN'(1)) ? ST_DONE : ST_SHFT;
                    end
                end
                ST_DONE: begin
                    if (!BGN) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign SEL         = (state == ST_LOAD);
    assign spi_MUX     = (state == ST_LOAD) || (state == ST_SHFT) ||
                         (state == ST_WRITE) || (state == ST_NEXT);
    assign CEN         = (state != ST_WRITE);
    assign D_WE        = (state != ST_WRITE);
    assign A           = (state == ST_WRITE) ? addr  : '0;
    assign PO          = (state == ST_WRITE) ? shreg : '0;
    assign spi_is_done = (state == ST_DONE);

endmodule
